// File: rtl/pow_job_scheduler_pkg.sv
// Shared types and default widths for the proof-of-work job scheduler.
package pow_pkg;

    localparam int DEF_BLOCK_BYTES = 12;
    localparam int DEF_NONCE_BYTES = 4;
    localparam int DEF_TARGET_W    = 16;
    localparam int DEF_JOB_DEPTH   = 4;
    localparam int DEF_TIMEOUT_W   = 16;
    localparam int DEF_CYC_W       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;

endpackage

// File: rtl/pow_job_scheduler_if.sv
// Job, core and result handshakes of the scheduler; slave = scheduler side.
interface pow_job_scheduler_if
    import pow_pkg::*;
#(
    parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int NONCE_BYTES = DEF_NONCE_BYTES,
    parameter int TARGET_W    = DEF_TARGET_W,
    parameter int TIMEOUT_W   = DEF_TIMEOUT_W,
    parameter int CYC_W       = DEF_CYC_W
);
    logic                     flush;
    logic                     job_valid;
    logic                     job_ready;
    logic [8*BLOCK_BYTES-1:0] job_block;
    logic [TARGET_W-1:0]      job_target;
    logic [TIMEOUT_W-1:0]     job_timeout;
    logic                     core_start;
    logic [8*BLOCK_BYTES-1:0] core_block;
    logic [TARGET_W-1:0]      core_target;
    logic                     core_finish;
    logic [8*NONCE_BYTES-1:0] core_nonce;
    logic                     res_valid;
    logic                     res_ready;
    logic [8*NONCE_BYTES-1:0] res_nonce;
    logic [CYC_W-1:0]         res_cycles;
    logic [1:0]               res_status;
    logic                     busy;

    modport slave (
        input  flush, job_valid, job_block, job_target, job_timeout,
               core_finish, core_nonce, res_ready,
        output job_ready, core_start, core_block, core_target,
               res_valid, res_nonce, res_cycles, res_status, busy
    );

    modport master (
        output flush, job_valid, job_block, job_target, job_timeout,
               core_finish, core_nonce, res_ready,
        input  job_ready, core_start, core_block, core_target,
               res_valid, res_nonce, res_cycles, res_status, busy
    );
endinterface

// File: rtl/pow_job_scheduler_fifo.sv
// Synchronous job FIFO with flush; rdata shows the head entry combinationally.
module pow_job_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    // flush beats any same-cycle push or pop
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pow_job_scheduler.sv
// Queues PoW jobs, runs them one at a time on the nonce core, times them and returns results.
module pow_job_scheduler
    import pow_pkg::*;
#(
    parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int NONCE_BYTES = DEF_NONCE_BYTES,
    parameter int TARGET_W    = DEF_TARGET_W,
    parameter int JOB_DEPTH   = DEF_JOB_DEPTH,
    parameter int TIMEOUT_W   = DEF_TIMEOUT_W,
    parameter int CYC_W       = DEF_CYC_W
) (
    input logic                 clk,
    input logic                 reset,
    pow_job_scheduler_if.slave  bus
);
    localparam int BW = 8*BLOCK_BYTES;
    localparam int NW = 8*NONCE_BYTES;
    localparam int JW = BW + TARGET_W + TIMEOUT_W;

    state_t               state, state_nxt;
    logic [JW-1:0]        fifo_rdata;
    logic                 fifo_full, fifo_empty, pop;
    logic [BW-1:0]        block_q;
    logic [TARGET_W-1:0]  target_q;
    logic [TIMEOUT_W-1:0] tmo_q;
    logic [CYC_W-1:0]     counter, cyc_next;
    logic                 timeout_hit;
    logic [NW-1:0]        nonce_q;
    logic [CYC_W-1:0]     cycles_q;
    logic [1:0]           status_q;
    logic                 start_c, valid_c;

    pow_job_fifo #(.WIDTH(JW), .DEPTH(JOB_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (bus.flush),
        .push  (bus.job_valid),
        .pop   (pop),
        .wdata ({bus.job_timeout, bus.job_target, bus.job_block}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pop         = (state == IDLE) && !fifo_empty && !bus.flush;
    // saturating count of the current RUN cycle, 1-based
    assign cyc_next    = (&counter) ? counter : counter + 1'b1;
    assign timeout_hit = (tmo_q != '0) && (cyc_next == CYC_W'(tmo_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        valid_c   = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) state_nxt = LOAD;
            LOAD: state_nxt = RUN;
            RUN: begin
                start_c = 1'b1;
                if (bus.core_finish || timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                valid_c = 1'b1;
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            block_q  <= '0;
            target_q <= '0;
            tmo_q    <= '0;
            counter  <= '0;
            nonce_q  <= '0;
            cycles_q <= '0;
            status_q <= ST_OK;
        end else begin
            if (pop) {tmo_q, target_q, block_q} <= fifo_rdata;
            if (state == LOAD)     counter <= '0;
            else if (state == RUN) counter <= cyc_next;
            // finish takes precedence over a timeout landing on the same cycle
            if (state == RUN && !bus.flush) begin
                if (bus.core_finish) begin
                    nonce_q  <= bus.core_nonce;
                    cycles_q <= cyc_next;
                    status_q <= ST_OK;
                end else if (timeout_hit) begin
                    nonce_q  <= '0;
                    cycles_q <= CYC_W'(tmo_q);
                    status_q <= ST_TIMEOUT;
                end
            end
        end
    end

    assign bus.job_ready   = !fifo_full;
    assign bus.core_start  = start_c;
    assign bus.core_block  = block_q;
    assign bus.core_target = target_q;
    assign bus.res_valid   = valid_c;
    assign bus.res_nonce   = nonce_q;
    assign bus.res_cycles  = cycles_q;
    assign bus.res_status  = status_q;
    assign bus.busy        = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pow_job_scheduler.sv
// Directed and randomized checks of pow_job_scheduler against a job-level reference model.
module tb_pow_job_scheduler;

    typedef struct {
        int          fin;
        logic [31:0] nonce;
    } plan_t;

    typedef struct {
        logic [31:0] nonce;
        int          cycles;
        logic [1:0]  status;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    plan_t plans[$];
    res_t  exp_q[$];
    int          cur_fin = 0;
    logic [31:0] cur_nonce = '0;
    int          run_cnt = 0;
    logic        stray = 1'b0;
    int          gap = 0;
    logic        seen = 1'b0;

    pow_job_scheduler_if bus ();

    pow_job_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Core model: finishes on the planned RUN cycle (1-based), 0 means never.
    always @(posedge bus.core_start) begin
        if (plans.size() != 0) begin
            plan_t p;
            p = plans.pop_front();
            cur_fin   = p.fin;
            cur_nonce = p.nonce;
        end else begin
            cur_fin = 0;
        end
    end

    always @(posedge clk) run_cnt <= bus.core_start ? run_cnt + 1 : 0;

    assign bus.core_finish = stray || (bus.core_start && cur_fin != 0 && run_cnt + 1 == cur_fin);
    assign bus.core_nonce  = cur_nonce;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // core_start must stay low at least two cycles before every restart
    always @(negedge clk) begin
        if (bus.core_start) begin
            if (seen && gap != 0) chk("start_gap", gap >= 2, 1);
            seen <= 1'b1;
            gap  <= 0;
        end else begin
            gap <= gap + 1;
        end
    end

    function automatic res_t model(input int fin, input logic [15:0] tmo, input logic [31:0] nonce);
        res_t r;
        if (fin != 0 && (tmo == 0 || fin <= int'(tmo))) begin
            r.nonce = nonce; r.cycles = fin; r.status = 2'd0;
        end else begin
            r.nonce = '0; r.cycles = int'(tmo); r.status = 2'd1;
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_job(input logic [95:0] blk, input logic [15:0] tgt, input logic [15:0] tmo,
                            input int fin, input logic [31:0] nonce, input bit track);
        int w;
        bus.job_valid   = 1'b1;
        bus.job_block   = blk;
        bus.job_target  = tgt;
        bus.job_timeout = tmo;
        w = 0;
        while (!bus.job_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("push_ready", bus.job_ready, 1);
        @(negedge clk);
        bus.job_valid = 1'b0;
        plans.push_back('{fin, nonce});
        if (track) exp_q.push_back(model(fin, tmo, nonce));
    endtask

    task automatic get_result(input bit chk_hi);
        int   hi, w;
        res_t e;
        hi = 0;
        w  = 0;
        while (!bus.res_valid && w < 2000) begin
            if (bus.core_start) hi++;
            @(negedge clk);
            w++;
        end
        chk("res_valid", bus.res_valid, 1);
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("res_nonce", bus.res_nonce, e.nonce);
            chk("res_cycles", bus.res_cycles, e.cycles);
            chk("res_status", bus.res_status, e.status);
            if (chk_hi) chk("run_len", hi, e.cycles);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("res_consumed", bus.res_valid, 0);
    endtask

    task automatic wait_start();
        int w;
        w = 0;
        while (!bus.core_start && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("start_seen", bus.core_start, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] blk0;
        logic [31:0] held_nonce;
        int          w;
        bus.flush = 0; bus.job_valid = 0; bus.job_block = '0;
        bus.job_target = '0; bus.job_timeout = '0; bus.res_ready = 0;

        // reset state
        @(negedge clk);
        chk("rst_job_ready", bus.job_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_core_start", bus.core_start, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_core_block", bus.core_block, 0);
        chk("rst_res_cycles", bus.res_cycles, 0);
        reset = 1'b0;
        @(negedge clk);

        // single job with start latency
        blk0 = 96'h24331F6B6C9ECA402F9F7D39;
        push_job(blk0, 16'd50, 16'd0, 150, 32'h0000_1234, 1);
        chk("lat_busy", bus.busy, 1);
        chk("lat_n1", bus.core_start, 0);
        @(negedge clk);
        chk("lat_n2", bus.core_start, 0);
        @(negedge clk);
        chk("lat_n3", bus.core_start, 1);
        chk("core_block", bus.core_block, blk0);
        chk("core_byte0", bus.core_block[7:0], 8'h39);
        chk("core_target", bus.core_target, 50);
        get_result(1);
        chk("idle_busy", bus.busy, 0);

        // timeout, finish on the timeout cycle, minimal timeout
        push_job(96'h1, 16'd7, 16'd100, 0, 32'hDEAD_BEEF, 1);
        get_result(1);
        push_job(96'h2, 16'd8, 16'd20, 20, 32'h0000_5A5A, 1);
        get_result(1);
        push_job(96'h3, 16'd9, 16'd1, 0, 32'h1111_2222, 1);
        get_result(1);

        // randomized jobs
        for (int i = 0; i < 8; i++) begin
            logic [15:0] tmo;
            int          fin;
            tmo = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            if (tmo == 0) fin = $urandom_range(1, 40);
            else          fin = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 45);
            push_job({$urandom, $urandom, $urandom}, 16'($urandom), tmo, fin, $urandom, 1);
            get_result(1);
        end

        // queue and backpressure: hold job 1 in DONE, fill the FIFO behind it
        held_nonce = 32'hCAFE_0001;
        push_job(96'hA1, 16'd1, 16'd0, 3, held_nonce, 1);
        w = 0;
        while (!bus.res_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("q_hold_valid", bus.res_valid, 1);
        push_job(96'hA2, 16'd2, 16'd0, 5, 32'hCAFE_0002, 1);
        chk("q_ready_1", bus.job_ready, 1);
        push_job(96'hA3, 16'd3, 16'd0, 9, 32'hCAFE_0003, 1);
        push_job(96'hA4, 16'd4, 16'd0, 2, 32'hCAFE_0004, 1);
        push_job(96'hA5, 16'd5, 16'd6, 12, 32'hCAFE_0005, 1);
        chk("q_full", bus.job_ready, 0);
        bus.job_valid = 1'b1;
        bus.job_block = 96'hA6;
        stray = 1'b1;
        repeat (5) @(negedge clk);
        chk("q_still_full", bus.job_ready, 0);
        chk("q_held_done", bus.res_valid, 1);
        chk("q_held_nonce", bus.res_nonce, held_nonce);
        chk("q_core_idle", bus.core_start, 0);
        bus.job_valid = 1'b0;
        stray = 1'b0;
        get_result(0);
        for (int i = 0; i < 4; i++) get_result(1);

        // flush mid-RUN with two jobs queued; a same-cycle push is dropped
        push_job(96'hB1, 16'd1, 16'd0, 0, 32'h0, 0);
        push_job(96'hB2, 16'd2, 16'd0, 0, 32'h0, 0);
        push_job(96'hB3, 16'd3, 16'd0, 0, 32'h0, 0);
        wait_start();
        repeat (5) @(negedge clk);
        bus.flush = 1'b1;
        bus.job_valid = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.job_valid = 1'b0;
        plans.delete();
        chk("fl_core_start", bus.core_start, 0);
        chk("fl_res_valid", bus.res_valid, 0);
        chk("fl_busy", bus.busy, 0);
        chk("fl_job_ready", bus.job_ready, 1);
        chk("fl_block_kept", bus.core_block, 96'hB1);
        repeat (10) @(negedge clk);
        chk("fl_quiet_start", bus.core_start, 0);
        chk("fl_quiet_valid", bus.res_valid, 0);

        // async reset between edges during RUN, then a fresh job
        push_job(96'hC1, 16'd77, 16'd0, 0, 32'h0, 0);
        wait_start();
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_core_start", bus.core_start, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_res_valid", bus.res_valid, 0);
        chk("ar_core_block", bus.core_block, 0);
        chk("ar_core_target", bus.core_target, 0);
        chk("ar_res_cycles", bus.res_cycles, 0);
        chk("ar_job_ready", bus.job_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        plans.delete();
        @(negedge clk);
        push_job(96'hD1, 16'd33, 16'd30, 7, 32'h0BAD_F00D, 1);
        get_result(1);
        chk("end_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
